// File: rtl/alu_pipe.sv
// Pipelined ALU: single-cycle ops plus an iterative shift-add MUL, valid/ready on both sides.
// Define ALU_PIPE_SAT_EN to make ADD/SUB saturate as unsigned instead of wrapping.
module alu_pipe #(
    parameter int WIDTH     = 8,
    parameter bit MUL_EN_OP = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] inputa,
    input  logic [WIDTH-1:0] inputb,
    input  logic [2:0]       op,
    input  logic             sc_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             sc_out,
    output logic             zero,
    output logic             beven,
    output logic             busy
);

    localparam int LOGW = $clog2(WIDTH);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_XOR = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_GBT = 3'd3;
    localparam logic [2:0] OP_SUB = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_SHR = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_HOLD
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [LOGW-1:0]    cnt;
    logic               last_iter;
    logic               accept;
    logic               is_mul;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   alu_out;
    logic               alu_sc;

    assign in_ready  = (state == S_IDLE) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign is_mul    = (op == OP_MUL) && MUL_EN_OP;
    assign busy      = (state == S_MUL);
    assign zero      = (out == '0);
    assign beven     = out[0];
    assign last_iter = (cnt == LOGW'(WIDTH - 1));

    // Single-cycle result; a disabled MUL falls through to the all-zero default.
    always_comb begin
        sum     = '0;
        alu_out = '0;
        alu_sc  = 1'b0;
        case (op)
            OP_ADD: begin
                sum     = {1'b0, inputa} + {1'b0, inputb} + {{WIDTH{1'b0}}, sc_in};
                alu_out = sum[WIDTH-1:0];
                alu_sc  = sum[WIDTH];
`ifdef ALU_PIPE_SAT_EN
                if (sum[WIDTH]) alu_out = '1;
`endif
            end
            OP_SUB: begin
                sum     = {1'b0, inputa} + {1'b0, ~inputb} + (WIDTH+1)'(1);
                alu_out = sum[WIDTH-1:0];
                alu_sc  = sum[WIDTH];
`ifdef ALU_PIPE_SAT_EN
                if (!sum[WIDTH]) alu_out = '0;
`endif
            end
            OP_XOR: alu_out = inputa ^ inputb;
            OP_AND: alu_out = inputa & inputb;
            OP_GBT: alu_out = {{(WIDTH-1){1'b0}}, inputa[inputb[LOGW-1:0]]};
            OP_SHL: begin
                alu_out = {inputa[WIDTH-2:0], sc_in};
                alu_sc  = inputa[WIDTH-1];
            end
            OP_SHR: begin
                alu_out = {sc_in, inputa[WIDTH-1:1]};
                alu_sc  = inputa[0];
            end
            default: begin
                alu_out = '0;
                alu_sc  = 1'b0;
            end
        endcase
    end

    assign acc_next = b_reg[0] ? acc + ({{WIDTH{1'b0}}, a_reg} << cnt) : acc;

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (accept && is_mul) state_next = S_MUL;
            S_MUL:   if (last_iter) state_next = S_HOLD;
            S_HOLD:  if (out_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // The final MUL iteration writes the result registers on the same edge it completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= '0;
            sc_out    <= 1'b0;
            out_valid <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            acc       <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (is_mul) begin
                            a_reg     <= inputa;
                            b_reg     <= inputb;
                            acc       <= '0;
                            cnt       <= '0;
                            out_valid <= 1'b0;
                        end else begin
                            out       <= alu_out;
                            sc_out    <= alu_sc;
                            out_valid <= 1'b1;
                        end
                    end else if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                S_MUL: begin
                    acc   <= acc_next;
                    b_reg <= b_reg >> 1;
                    cnt   <= cnt + LOGW'(1);
                    if (last_iter) begin
                        out       <= acc_next[WIDTH-1:0];
                        sc_out    <= |acc_next[2*WIDTH-1:WIDTH];
                        out_valid <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: out_valid <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe: an 8-bit instance for most checks, a 16-bit one for shifts.
module tb_alu_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       in_valid, in_ready, sc_in, out_valid, out_ready;
    logic [7:0] inputa, inputb, out;
    logic [2:0] op;
    logic       sc_out, zero, beven, busy;

    logic        in_valid16, in_ready16, sc_in16, out_valid16;
    logic [15:0] inputa16, inputb16, out16;
    logic [2:0]  op16;
    logic        sc_out16, zero16, beven16, busy16;

    int tests_run    = 0;
    int tests_failed = 0;

`ifdef ALU_PIPE_SAT_EN
    localparam logic [7:0] ADD_EXP = 8'hFF;
    localparam logic [7:0] SUB_EXP = 8'h00;
`else
    localparam logic [7:0] ADD_EXP = 8'h11;
    localparam logic [7:0] SUB_EXP = 8'hFE;
`endif

    alu_pipe #(.WIDTH(8), .MUL_EN_OP(1'b1)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .inputa(inputa), .inputb(inputb), .op(op), .sc_in(sc_in),
        .out_valid(out_valid), .out_ready(out_ready), .out(out), .sc_out(sc_out),
        .zero(zero), .beven(beven), .busy(busy)
    );

    alu_pipe #(.WIDTH(16), .MUL_EN_OP(1'b1)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
        .inputa(inputa16), .inputb(inputb16), .op(op16), .sc_in(sc_in16),
        .out_valid(out_valid16), .out_ready(1'b1), .out(out16), .sc_out(sc_out16),
        .zero(zero16), .beven(beven16), .busy(busy16)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one op for exactly one cycle once the DUT is ready; returns just after the accepting edge.
    task automatic applyStimulus(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b, input logic s);
        int n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        if (n == 20) checkOutput("in_ready_timeout", in_ready, 1);
        op       = o;
        inputa   = a;
        inputb   = b;
        sc_in    = s;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic waitResult(input string tag, output int edges);
        edges = 0;
        while (!out_valid && edges < 20) begin
            tick();
            edges++;
        end
        if (edges == 20) checkOutput(tag, out_valid, 1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int edges;
        int busy_cycles;

        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1; sc_in = 1'b0;
        inputa = '0; inputb = '0; op = '0;
        in_valid16 = 1'b0; sc_in16 = 1'b0; inputa16 = '0; inputb16 = '0; op16 = '0;
        #12;
        checkOutput("rst_out", out, 0);
        checkOutput("rst_zero", zero, 1);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_in_ready", in_ready, 1);
        tick();
        rst_n = 1'b1;
        tick();

        // Back-to-back single-cycle ops, one result per cycle
        applyStimulus(3'd0, 8'hF0, 8'h20, 1'b1);
        checkOutput("add_out", out, ADD_EXP);
        checkOutput("add_sc", sc_out, 1);
        checkOutput("add_valid", out_valid, 1);
        checkOutput("add_in_ready", in_ready, 1);
        applyStimulus(3'd4, 8'h05, 8'h07, 1'b1);
        checkOutput("sub_out", out, SUB_EXP);
        checkOutput("sub_sc", sc_out, 0);
        checkOutput("sub_valid", out_valid, 1);
        applyStimulus(3'd3, 8'h04, 8'h02, 1'b0);
        checkOutput("gbt_out", out, 8'h01);
        checkOutput("gbt_beven", beven, 1);
        checkOutput("gbt_zero", zero, 0);
        applyStimulus(3'd3, 8'h80, 8'hFF, 1'b0);
        checkOutput("gbt_hi_b_ignored", out, 8'h01);
        applyStimulus(3'd4, 8'h07, 8'h05, 1'b0);
        checkOutput("sub_noborrow_out", out, 8'h02);
        checkOutput("sub_noborrow_sc", sc_out, 1);
        applyStimulus(3'd2, 8'h3C, 8'h0F, 1'b1);
        checkOutput("and_out", out, 8'h0C);
        checkOutput("and_sc", sc_out, 0);
        tick();
        checkOutput("drain_valid", out_valid, 0);

        // MUL 13*11, operands changed right after accept must not matter
        applyStimulus(3'd7, 8'd13, 8'd11, 1'b0);
        inputa = 8'hFF;
        inputb = 8'hFF;
        checkOutput("mul_in_ready_low", in_ready, 0);
        checkOutput("mul_valid_low", out_valid, 0);
        busy_cycles = 0;
        edges = 0;
        while (!out_valid && edges < 20) begin
            if (busy) busy_cycles++;
            tick();
            edges++;
        end
        // Latency counts the accept cycle, so single-cycle ops measure 1 here
        checkOutput("mul_latency", edges + 1, 9);
        checkOutput("mul_busy_cycles", busy_cycles, 8);
        checkOutput("mul_out", out, 8'h8F);
        checkOutput("mul_sc", sc_out, 0);
        checkOutput("mul_busy_done", busy, 0);

        applyStimulus(3'd7, 8'h20, 8'h10, 1'b0);
        waitResult("mul2_timeout", edges);
        checkOutput("mul2_out", out, 8'h00);
        checkOutput("mul2_sc", sc_out, 1);
        checkOutput("mul2_zero", zero, 1);
        tick();

        // Backpressure: XOR result held while the consumer stalls
        out_ready = 1'b0;
        applyStimulus(3'd1, 8'hAA, 8'hAA, 1'b0);
        checkOutput("xor_out", out, 8'h00);
        checkOutput("xor_zero", zero, 1);
        op = 3'd2; inputa = 8'h3C; inputb = 8'h0F; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("bp_hold_out", out, 8'h00);
            checkOutput("bp_hold_valid", out_valid, 1);
            checkOutput("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        #1;
        checkOutput("bp_release_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        checkOutput("bp_next_out", out, 8'h0C);
        checkOutput("bp_next_valid", out_valid, 1);
        tick();

        // Reset asserted during the third MUL iteration
        applyStimulus(3'd7, 8'd13, 8'd11, 1'b0);
        tick();
        tick();
        checkOutput("rstmul_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("rstmul_out", out, 0);
        checkOutput("rstmul_sc", sc_out, 0);
        checkOutput("rstmul_zero", zero, 1);
        checkOutput("rstmul_beven", beven, 0);
        checkOutput("rstmul_valid", out_valid, 0);
        checkOutput("rstmul_busy", busy, 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("rstmul_no_spurious_valid", out_valid, 0);
            checkOutput("rstmul_in_ready", in_ready, 1);
        end

        // Shifts on the 16-bit instance
        op16 = 3'd5; inputa16 = 16'h8001; sc_in16 = 1'b1; in_valid16 = 1'b1;
        tick();
        checkOutput("shl16_out", out16, 16'h0003);
        checkOutput("shl16_sc", sc_out16, 1);
        op16 = 3'd6; inputa16 = 16'h0001; sc_in16 = 1'b0;
        tick();
        in_valid16 = 1'b0;
        checkOutput("shr16_out", out16, 16'h0000);
        checkOutput("shr16_sc", sc_out16, 1);
        checkOutput("shr16_zero", zero16, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
